// File: rtl/matrix_pkg.sv
// Shared types and defaults for the banked matrix storage datapath.
package matrix_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ROWS   = 1024;
    localparam int unsigned DEF_COLS   = 1024;
    localparam int unsigned DEF_NBANKS = 16;

    // Banks own contiguous row blocks, so the bank index is the top address bits.
    function automatic int unsigned bank_of(input logic [63:0] addr,
                                            input int unsigned addr_w,
                                            input int unsigned bank_w);
        return 32'(addr >> (addr_w - bank_w));
    endfunction

endpackage

// File: rtl/matrix_bank_ram.sv
// Single-port bank RAM: synchronous write, registered read (read-first).
module matrix_bank_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 65536,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/matrix_bank_dp.sv
// Banked ROWS x COLS matrix store with one request port, 2-cycle reads and a clear sweep.
module matrix_bank_dp
    import matrix_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ROWS    = DEF_ROWS,
    parameter int unsigned COLS    = DEF_COLS,
    parameter int unsigned NBANKS  = DEF_NBANKS,
    localparam int unsigned ADDR_W = $clog2(ROWS * COLS),
    localparam int unsigned BANK_W = $clog2(NBANKS),
    localparam int unsigned LOC_W  = ADDR_W - BANK_W,
    localparam int unsigned DEPTH  = 2 ** LOC_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done
);

    state_e            state_q, state_d;
    logic [LOC_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;

    logic              s1_valid_q, s1_we_q;
    logic [BANK_W-1:0] s1_bank_q;
    logic [LOC_W-1:0]  s1_loc_q;
    logic [DATA_W-1:0] s1_wdata_q;
    logic              s2_valid_q;
    logic [BANK_W-1:0] s2_bank_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    logic              accept;
    logic [DATA_W-1:0] bank_rdata [NBANKS];

    assign req_ready = (state_q == ST_IDLE) & ~clr_start & ~RST;
    assign accept    = req_valid & req_ready;
    assign clr_busy  = (state_q == ST_CLEAR);
    assign clr_done  = done_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_we_q     <= 1'b0;
            s1_bank_q   <= '0;
            s1_loc_q    <= '0;
            s1_wdata_q  <= '0;
            s2_valid_q  <= 1'b0;
            s2_bank_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            s1_valid_q  <= accept;
            s1_we_q     <= req_we;
            s1_bank_q   <= BANK_W'(bank_of(64'(req_addr), ADDR_W, BANK_W));
            s1_loc_q    <= req_addr[LOC_W-1:0];
            s1_wdata_q  <= req_wdata;
            s2_valid_q  <= s1_valid_q & ~s1_we_q;
            s2_bank_q   <= s1_bank_q;
            rsp_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                rsp_rdata_q <= bank_rdata[s2_bank_q];
            end
        end
    end

    // The sweep owns every bank port while clearing; no request can be in stage 1 then.
    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        logic              we;
        logic [LOC_W-1:0]  addr;
        logic [DATA_W-1:0] wdata;

        always_comb begin
            we    = 1'b0;
            addr  = s1_loc_q;
            wdata = s1_wdata_q;
            if (state_q == ST_CLEAR) begin
                we    = ~RST;
                addr  = cnt_q;
                wdata = '0;
            end else begin
                we = s1_valid_q & s1_we_q & (s1_bank_q == BANK_W'(b)) & ~RST;
            end
        end

        matrix_bank_ram #(
            .DATA_W(DATA_W),
            .DEPTH (DEPTH)
        ) u_ram (
            .CLK  (CLK),
            .we   (we),
            .addr (addr),
            .wdata(wdata),
            .rdata(bank_rdata[b])
        );
    end

endmodule
